// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display blocks:
//   HEX_SEG_TABLE : hex nibble -> segment pattern (a..g on bits 0..6, active-high)
//   SEG_BLANK     : all segments off
//   scan_state_t  : scan controller states
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is the rightmost entry: HEX_SEG_TABLE[4'hX] is the glyph for X.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to seven-segment decoder.
//   hex : 4-bit value 0..F
//   seg : segments a..g on bits 0..6, active-high
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a common-cathode seven-segment display.
// A new value is accepted over valid/ready into a shadow register and copied to
// the active register only on a frame boundary (or straight away while idle).
// Each digit gets a TICK_DIV-cycle slot: BLANK dark cycles, then lit until the
// brightness-dependent on-limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : 1 = scan, 0 = idle with the display blank
//   wr_valid   : new display value offered
//   wr_ready   : shadow register free
//   wr_data    : packed hex nibbles, nibble 0 = digit 0 (rightmost)
//   bright     : on-time per slot = (bright+1)/4 of the slot
//   seg_out    : segments a..g, active-high (registered)
//   digit_sel  : one-hot digit enable, all-zero = blank (registered)
//   frame_tick : one-cycle pulse on the last cycle of each frame (registered)
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int BLANK      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [1:0]              bright,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_tick
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [31:0]       QUARTER   = 32'(TICK_DIV / 4);

    scan_state_t             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [1:0]              bright_q, bright_src;
    logic [31:0]             on_limit;
    logic                    lit;
    logic [3:0]              nibble;
    logic [6:0]              seg_dec;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   digit_sel_d;
    logic                    frame_tick_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, active_q;
    logic                    pending_q;
    logic                    accept, commit;

    // ---------------------------------------------------------------- state --
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    // ----------------------------------------------------------- next state --
    // NOTE: every always_comb output gets a default first so no path can infer
    // a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ena)  state_d = SCAN;
            SCAN:    if (!ena) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters run only while staying in SCAN; entering or leaving SCAN
    // starts from cnt=slot=0.
    always_comb begin
        cnt_d  = '0;
        slot_d = '0;
        if (state_q == SCAN && state_d == SCAN) begin
            if (cnt_q == CNT_LAST) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                slot_d = slot_q;
            end
        end
    end

    // -------------------------------------------------------------- outputs --
    // Outputs are registered from the next cnt/slot so that they line up with
    // the counters in the cycle they describe. Brightness for a slot is the
    // value seen during its cnt=0 cycle; cnt=0 itself is always dark.
    assign bright_src = (cnt_q == '0) ? bright : bright_q;
    assign nibble     = active_q[4*slot_d +: 4];

    seg7_hex_decode u_hex_decode (
        .hex (nibble),
        .seg (seg_dec)
    );

    always_comb begin
        on_limit     = (32'(bright_src) + 32'd1) * QUARTER;
        lit          = (state_d == SCAN)
                    && (32'(cnt_d) >= 32'(BLANK))
                    && (32'(cnt_d) <  on_limit);
        digit_sel_d  = '0;
        seg_d        = SEG_BLANK;
        if (lit) begin
            digit_sel_d = NUM_DIGITS'(1) << slot_d;
            seg_d       = seg_dec;
        end
        frame_tick_d = (state_d == SCAN) && (slot_d == SLOT_LAST)
                    && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= SEG_BLANK;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_d;
            digit_sel  <= digit_sel_d;
            frame_tick <= frame_tick_d;
        end
    end

    // ------------------------------------------------- handshake and buffers --
    // accept needs !pending and commit needs pending, so they never coincide.
    // In SCAN a commit lands on the frame_tick cycle, so the new value is first
    // used at cnt=0 of the next frame, which is always dark.
    assign wr_ready = !pending_q;
    assign accept   = wr_valid && !pending_q;
    assign commit   = pending_q && (state_q == IDLE || frame_tick);

    // NOTE: the value registers are reset explicitly because the display must
    // show 0x0 on every digit after reset, not whatever the flops powered up as.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            bright_q  <= '0;
        end else begin
            if (accept) begin
                shadow_q  <= wr_data;
                pending_q <= 1'b1;
            end else if (commit) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (cnt_q == '0) begin
                bright_q <= bright;
            end
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-cathode seven-segment display. It sits between the seconds/counter logic and the chip's dedicated outputs. It accepts a packed hex value over a valid/ready handshake and double-buffers it so updates land only on frame boundaries. It then sequences one digit at a time onto a shared segment bus, with anti-ghosting blanking and 4-level brightness control.

## Interface
- `NUM_DIGITS`, default 4: digits scanned, 1..8.
- `TICK_DIV`, default 1000: clock cycles per digit slot; must be a multiple of 4 and ≥ 8.
- `BLANK`, default 2: cycles at the start of each slot with all digits off.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset; asynchronous and active-low.
- `ena`  in  1: design enabled; low = idle, display blank.
- `wr_valid`  in  1: new display value offered.
- `wr_ready`  out  1: shadow register free; transfer when `wr_valid && wr_ready`.
- `wr_data`  in  4*NUM_DIGITS: hex nibbles; nibble 0 (LSBs) = digit 0 (rightmost).
- `bright`  in  2: on-time per slot = (bright+1)/4 of the slot.
- `seg_out`  out  7: segments a..g on bits 0..6, active-high.
- `digit_sel`  out  NUM_DIGITS: one-hot active-high digit enable; all-zero = blank.
- `frame_tick`  out  1: one-cycle pulse on the last cycle of each frame.

## Operation
- State machine:
  - IDLE while `ena`=0.
  - IDLE→SCAN on `ena`=1; SCAN→IDLE on `ena`=0, from any cycle.
- Counters:
  - `cnt` counts 0..TICK_DIV-1; wrap advances `slot` 0..NUM_DIGITS-1.
  - `slot` wraps to 0.
  - A frame is NUM_DIGITS*TICK_DIV cycles.
- Digit enable: `on_limit = (bright+1)*(TICK_DIV/4)`. `digit_sel[slot]`=1 iff SCAN and `BLANK ≤ cnt < on_limit`; otherwise all zero.
- `seg_out` = hex decode of active nibble `slot` while `digit_sel`≠0, else 0.
  - Decode covers 0..F: 0→0x3F, 1→0x06, 8→0x7F, A→0x77, F→0x71.
- Double buffering:
  - Accepted `wr_data` goes to shadow and sets `pending`; `wr_ready` = !`pending`.
  - In SCAN, shadow→active on the `frame_tick` cycle; `pending` clears and `wr_ready` rises the next cycle.
  - In IDLE, shadow→active the cycle after acceptance.
- `bright` is sampled at slot start (cnt=0) and held for the whole slot.
- `frame_tick` = SCAN && slot=NUM_DIGITS-1 && cnt=TICK_DIV-1.

## Timing
- Reset values:
  - `seg_out`=0, `digit_sel`=0, `frame_tick`=0, `wr_ready`=1.
  - Active and shadow registers = 0; `cnt`=`slot`=0; state IDLE.
- Outputs are registered and aligned with `cnt`/`slot` as defined above; no combinational path from any input to any output.
- The first SCAN cycle after `ena` rises has cnt=0, slot=0.
- Dropping `ena` forces `cnt`=`slot`=0 and blanks outputs on the next cycle. A pending shadow then commits per IDLE rule.
- A handshake in the same cycle as `frame_tick` is impossible, since `wr_ready`=0 while pending. When `pending`=0, acceptance on the `frame_tick` cycle commits at the *next* frame boundary.
- `wr_data` and `wr_valid` changes while `wr_ready`=0 are ignored.
- Reset asserted mid-frame returns all state to reset values asynchronously.
- Frame boundaries are glitch-free: `digit_sel` is never more than one-hot, and `digit_sel` is always all-zero for cycle cnt=0 (BLANK ≥ 1).

## Structure
- Shared package `seg7_pkg`:
  - 16-entry hex→segment constant table;
  - `SEG_BLANK` constant (7'h00);
  - state enum {IDLE, SCAN}.
- Natural sub-module: `seg7_hex_decode` (4-bit in, 7-bit out, combinational), shared with other display blocks.
- The top of the block holds the counters, FSM, handshake/shadow registers and output registers.

## Test plan
All scenarios use TICK_DIV=8, BLANK=2, NUM_DIGITS=4.
1. Reset, then `ena`=1, write 0x1234, `bright`=3 → within each 8-cycle slot, `digit_sel` is 0 for cnt 0..1 and one-hot for cnt 2..7. Digit 0 shows 0x66 ('4'), then digits 1..3 show '3','2','1'. `frame_tick` pulses every 32 cycles.
2. `bright`=0 → `digit_sel` is high only for cnt 2..1, i.e. never (on_limit=2); `bright`=1 → high for cnt 2..3 only; `seg_out`=0 whenever `digit_sel`=0.
3. Write 0xAAAA mid-frame while scanning 0x1234 → `wr_ready` drops the cycle after acceptance. Display stays 0x1234 until `frame_tick`, then shows 0x77 on all digits from the next frame; `wr_ready` returns to 1 one cycle after `frame_tick`.
4. Second write offered while pending → not accepted (`wr_ready`=0); the first value is displayed. Offer held across the boundary → accepted the cycle `wr_ready` rises.
5. `ena` dropped at slot 2, cnt 5 → next cycle `digit_sel`=0 and `seg_out`=0. `ena` re-raised → scan restarts at slot 0, cnt 0. Write during IDLE → `wr_ready` returns to 1 two cycles after acceptance.
6. `rst_n` pulsed low mid-slot with a write pending → outputs 0 immediately; `wr_ready`=1; display value after re-enable is 0x0000 (all digits 0x3F).
